// File: rtl/lcd_hex_driver_pkg.sv
// Shared definitions for the HD44780 hex display driver.
// Contains the LCD command bytes, the sequencer and write-engine state types,
// and the nibble/command lookup helpers.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_LINE1     = 8'h80;
    localparam logic [7:0] CMD_LINE2     = 8'hC0;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_L1_ADDR,
        ST_L1_CHAR,
        ST_L2_ADDR,
        ST_L2_CHAR,
        ST_FLUSH,
        ST_IDLE
    } lcd_state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } phy_phase_t;

    // Upper-case ASCII for one hex nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Power-on command list, issued in index order.
    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return CMD_FUNC_8B2L;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_ENTRY_INC;
            default: return CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_hex_driver_if.sv
// Value hand-off between a result-producing datapath and the LCD driver.
interface lcd_hex_driver_if #(parameter int DATA_W = 8);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;

    modport master (output in_valid, in_data, input in_ready, busy);
    modport slave  (input in_valid, in_data, output in_ready, busy);
endinterface

// File: rtl/lcd_write_phy.sv
// One strobed LCD bus write: RS/DATA setup, EN pulse, then a settle wait
// (long wait after Clear Display). ready is also high in the last wait cycle
// so the sequencer can chain writes with no idle cycle between them.
module lcd_write_phy
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 25,
    parameter int T_CMD   = 2500,
    parameter int T_CLR   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       ready,
    output logic       done,
    output logic       LCD_EN,
    output logic       LCD_RS,
    output logic [7:0] LCD_DATA
);

    localparam int T_MAX = (T_CLR > T_CMD) ?
                           ((T_CLR > T_EN) ? ((T_CLR > T_SETUP) ? T_CLR : T_SETUP) : ((T_EN > T_SETUP) ? T_EN : T_SETUP)) :
                           ((T_CMD > T_EN) ? ((T_CMD > T_SETUP) ? T_CMD : T_SETUP) : ((T_EN > T_SETUP) ? T_EN : T_SETUP));
    localparam int CW = $clog2(T_MAX + 1);

    phy_phase_t    phase, phase_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          en_n, rs_n, long_q, long_n;
    logic [7:0]    data_n;

    assign done  = (phase == PH_WAIT) && (cnt == '0);
    assign ready = (phase == PH_IDLE) || done;

    // Phase, down-counter and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            LCD_EN   <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= 8'h00;
        end else begin
            phase    <= phase_n;
            cnt      <= cnt_n;
            long_q   <= long_n;
            LCD_EN   <= en_n;
            LCD_RS   <= rs_n;
            LCD_DATA <= data_n;
        end
    end

    // Next phase: each phase ends on terminal count; a new start overrides.
    always_comb begin
        phase_n = phase;
        cnt_n   = cnt;
        long_n  = long_q;
        en_n    = LCD_EN;
        rs_n    = LCD_RS;
        data_n  = LCD_DATA;
        case (phase)
            PH_SETUP: begin
                if (cnt == '0) begin
                    phase_n = PH_PULSE;
                    cnt_n   = CW'(T_EN - 1);
                    en_n    = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            PH_PULSE: begin
                if (cnt == '0) begin
                    phase_n = PH_WAIT;
                    cnt_n   = long_q ? CW'(T_CLR - 1) : CW'(T_CMD - 1);
                    en_n    = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            PH_WAIT: begin
                if (cnt == '0) phase_n = PH_IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            default: ;
        endcase
        if (start && ready) begin
            phase_n = PH_SETUP;
            cnt_n   = CW'(T_SETUP - 1);
            long_n  = long_wait;
            en_n    = 1'b0;
            rs_n    = rs;
            data_n  = data;
        end
    end

endmodule

// File: rtl/lcd_hex_driver.sv
// HD44780 16x2 driver showing a DATA_W-bit value as hex on line 1.
// Optional build macro LCD_LINE2_EN adds line 2 with the previous value.
//
// state       | meaning
// ------------+------------------------------------------------------
// PWR_WAIT    | power-up delay before any command
// INIT        | function set, display on, entry mode, clear
// L1_ADDR     | set DDRAM address to line 1
// L1_CHAR     | 16 characters of "Result: 0x<hex>"
// L2_ADDR     | set DDRAM address to line 2 (LCD_LINE2_EN only)
// L2_CHAR     | 16 characters of "Prev:   0x<hex>" (LCD_LINE2_EN only)
// FLUSH       | last write issued, waiting for its settle time
// IDLE        | ready for a new value
module lcd_hex_driver
    import lcd_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int T_PWR   = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 25,
    parameter int T_CMD   = 2500,
    parameter int T_CLR   = 100000
) (
    input  logic             clk,
    input  logic             rst,
    lcd_hex_driver_if.slave  bus,
    output logic [7:0]       LCD_DATA,
    output logic             LCD_RS,
    output logic             LCD_RW,
    output logic             LCD_EN,
    output logic             LCD_ON,
    output logic             LCD_BLON
);

    localparam int ND = DATA_W / 4;
    localparam int PW = $clog2(T_PWR + 1);
    localparam logic [79:0] TXT_L1 = "Result: 0x";

    lcd_state_t        state, state_n;
    logic [3:0]        idx, idx_n;
    logic [PW-1:0]     pwr_cnt, pwr_n;
    logic [DATA_W-1:0] held, held_n;
    logic              wr_start, wr_rs, wr_long;
    logic [7:0]        wr_data;
    logic              phy_ready, phy_done;

`ifdef LCD_LINE2_EN
    localparam logic [79:0] TXT_L2 = "Prev:   0x";
    // Only line 2 ever shows the previous value, so it exists only with line 2.
    logic [DATA_W-1:0] prev, prev_n;

    // Previous-value register.
    always_ff @(posedge clk) begin
        if (rst) prev <= '0;
        else     prev <= prev_n;
    end
`endif

    // Character i of a 16-character line: 10-char prefix, hex digits MSB-first, spaces.
    function automatic logic [7:0] text_char(input logic [3:0] i, input logic [79:0] prefix,
                                             input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] sh;
        int                k;
        text_char = 8'h20;
        if (i < 4'd10) begin
            text_char = prefix[79 - 8*int'(i) -: 8];
        end else begin
            k = int'(i) - 10;
            if (k < ND) begin
                sh        = v >> (4 * (ND - 1 - k));
                text_char = hex_ascii(sh[3:0]);
            end
        end
    endfunction

    // Sequencer state, character index, power-up timer and held value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_PWR_WAIT;
            idx     <= 4'd0;
            pwr_cnt <= PW'(T_PWR - 1);
            held    <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            pwr_cnt <= pwr_n;
            held    <= held_n;
        end
    end

    // Next-state and write request; a write is issued whenever the phy can take it.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        pwr_n    = pwr_cnt;
        held_n   = held;
`ifdef LCD_LINE2_EN
        prev_n   = prev;
`endif
        wr_start = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = 8'h00;
        wr_long  = 1'b0;
        case (state)
            ST_PWR_WAIT: begin
                if (pwr_cnt == '0) begin
                    state_n = ST_INIT;
                    idx_n   = 4'd0;
                end else begin
                    pwr_n = pwr_cnt - PW'(1);
                end
            end
            ST_INIT: begin
                wr_start = phy_ready;
                wr_data  = init_cmd(idx[1:0]);
                wr_long  = (wr_data == CMD_CLEAR);
                if (phy_ready) begin
                    if (idx == 4'd3) begin
                        state_n = ST_L1_ADDR;
                        idx_n   = 4'd0;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            ST_L1_ADDR: begin
                wr_start = phy_ready;
                wr_data  = CMD_LINE1;
                if (phy_ready) begin
                    state_n = ST_L1_CHAR;
                    idx_n   = 4'd0;
                end
            end
            ST_L1_CHAR: begin
                wr_start = phy_ready;
                wr_rs    = 1'b1;
                wr_data  = text_char(idx, TXT_L1, held);
                if (phy_ready) begin
                    idx_n = idx + 4'd1;
                    if (idx == 4'd15) begin
`ifdef LCD_LINE2_EN
                        state_n = ST_L2_ADDR;
`else
                        state_n = ST_FLUSH;
`endif
                    end
                end
            end
`ifdef LCD_LINE2_EN
            ST_L2_ADDR: begin
                wr_start = phy_ready;
                wr_data  = CMD_LINE2;
                if (phy_ready) begin
                    state_n = ST_L2_CHAR;
                    idx_n   = 4'd0;
                end
            end
            ST_L2_CHAR: begin
                wr_start = phy_ready;
                wr_rs    = 1'b1;
                wr_data  = text_char(idx, TXT_L2, prev);
                if (phy_ready) begin
                    idx_n = idx + 4'd1;
                    if (idx == 4'd15) state_n = ST_FLUSH;
                end
            end
`endif
            ST_FLUSH: begin
                if (phy_done) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.in_valid) begin
`ifdef LCD_LINE2_EN
                    prev_n = held;
`endif
                    held_n  = bus.in_data;
                    state_n = ST_L1_ADDR;
                end
            end
            default: state_n = ST_PWR_WAIT;
        endcase
    end

    assign bus.in_ready = (state == ST_IDLE);
    assign bus.busy     = (state != ST_IDLE);
    assign LCD_RW       = 1'b0;
    assign LCD_ON       = 1'b1;
    assign LCD_BLON     = 1'b1;

    lcd_write_phy #(
        .T_SETUP (T_SETUP),
        .T_EN    (T_EN),
        .T_CMD   (T_CMD),
        .T_CLR   (T_CLR)
    ) u_phy (
        .clk       (clk),
        .rst       (rst),
        .start     (wr_start),
        .rs        (wr_rs),
        .data      (wr_data),
        .long_wait (wr_long),
        .ready     (phy_ready),
        .done      (phy_done),
        .LCD_EN    (LCD_EN),
        .LCD_RS    (LCD_RS),
        .LCD_DATA  (LCD_DATA)
    );

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Self-checking bench for lcd_hex_driver. A bus monitor records every EN strobe
// (RS/DATA, rise cycle, width, setup and hold); the expected strobe list is
// built from the display text rules. With LCD_LINE2_EN the value is 24 bits.
module tb_lcd_hex_driver;

`ifdef LCD_LINE2_EN
    localparam int DW = 24;
    localparam bit L2 = 1'b1;
`else
    localparam int DW = 8;
    localparam bit L2 = 1'b0;
`endif
    localparam int ND      = DW / 4;
    localparam int T_PWR   = 10;
    localparam int T_SETUP = 2;
    localparam int T_EN    = 3;
    localparam int T_CMD   = 5;
    localparam int T_CLR   = 20;
    localparam int LIMIT   = 3000;

    logic       clk;
    logic       rst;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic [8:0] bus9;

    lcd_hex_driver_if #(.DATA_W(DW)) hs ();

    lcd_hex_driver #(
        .DATA_W (DW), .T_PWR (T_PWR), .T_SETUP (T_SETUP),
        .T_EN (T_EN), .T_CMD (T_CMD), .T_CLR (T_CLR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (hs),
        .LCD_DATA (lcd_data),
        .LCD_RS   (lcd_rs),
        .LCD_RW   (lcd_rw),
        .LCD_EN   (lcd_en),
        .LCD_ON   (lcd_on),
        .LCD_BLON (lcd_blon)
    );

    assign bus9 = {lcd_rs, lcd_data};

    int         cyc = 0;
    int         passed = 0;
    int         total = 0;
    logic [8:0] wr_q[$];
    logic [8:0] exp_q[$];
    int         rise_q[$], width_q[$], setup_q[$], hold_q[$];
    string      hexchars = "0123456789ABCDEF";
    logic [DW-1:0] m_held, m_prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus monitor, sampled on the falling clock edge.
    logic [8:0] m_prev_bus, m_lat;
    bit         m_prev_en, m_bad;
    int         m_width, m_stable;
    initial begin
        m_prev_bus = '0; m_lat = '0; m_prev_en = 0; m_bad = 0; m_width = 0; m_stable = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_prev_en = 0; m_stable = 0; m_bad = 0; m_width = 0;
            end else begin
                if (!lcd_en) begin
                    if (m_prev_en) begin
                        width_q.push_back(m_width);
                        hold_q.push_back((!m_bad && (bus9 == m_lat)) ? 1 : 0);
                    end
                    if (bus9 == m_prev_bus) m_stable++;
                    else                    m_stable = 1;
                end else if (!m_prev_en) begin
                    wr_q.push_back(bus9);
                    rise_q.push_back(cyc);
                    setup_q.push_back(m_stable);
                    m_lat = bus9; m_width = 1; m_bad = 0;
                end else begin
                    m_width++;
                    if (bus9 != m_lat) m_bad = 1;
                end
                m_prev_en  = lcd_en;
            end
            m_prev_bus = bus9;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete(); rise_q.delete(); width_q.delete(); setup_q.delete(); hold_q.delete();
        exp_q.delete();
    endtask

    task automatic model_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic model_line(input logic [7:0] addr, input string prefix, input logic [DW-1:0] v);
        exp_q.push_back({1'b0, addr});
        for (int i = 0; i < 16; i++) begin
            byte c;
            int  n;
            if (i < prefix.len()) begin
                c = prefix[i];
            end else if (i < prefix.len() + ND) begin
                n = int'((v >> (4 * (ND - 1 - (i - prefix.len())))) & 'hF);
                c = hexchars[n];
            end else begin
                c = " ";
            end
            exp_q.push_back({1'b1, c});
        end
    endtask

    task automatic model_redraw();
        model_line(8'h80, "Result: 0x", m_held);
        if (L2) model_line(8'hC0, "Prev:   0x", m_prev);
    endtask

    task automatic check_burst(input string tag);
        int n;
        int gap;
        chk({tag, "_count"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
            chk($sformatf("%s_width%0d", tag, i), width_q[i], T_EN);
            chk($sformatf("%s_hold%0d", tag, i), hold_q[i], 1);
            chk($sformatf("%s_setup%0d", tag, i), (setup_q[i] >= T_SETUP) ? 1 : 0, 1);
            if (i > 0) begin
                gap = T_SETUP + T_EN + ((exp_q[i-1] == 9'h001) ? T_CLR : T_CMD);
                chk($sformatf("%s_gap%0d", tag, i), rise_q[i] - rise_q[i-1], gap);
            end
        end
    endtask

    task automatic wait_ready(input string tag, output int rc);
        bit ok;
        ok = 0;
        rc = 0;
        for (int i = 0; i < LIMIT; i++) begin
            if (hs.in_ready) begin
                ok = 1;
                rc = cyc;
                break;
            end
            tick();
        end
        chk({tag, "_ready_timeout"}, ok, 1);
    endtask

    task automatic send(input logic [DW-1:0] v, output int acc);
        bit ok;
        ok = 0;
        acc = 0;
        hs.in_valid = 1'b1;
        hs.in_data  = v;
        for (int i = 0; i < LIMIT; i++) begin
            if (hs.in_ready) begin
                ok  = 1;
                acc = cyc;
                @(posedge clk);
                #1;
                break;
            end
            tick();
        end
        hs.in_valid = 1'b0;
        chk("accept_timeout", ok, 1);
        m_prev = m_held;
        m_held = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, lcd_data, 8'h00);
        chk({tag, "_rs"}, lcd_rs, 1'b0);
        chk({tag, "_rw"}, lcd_rw, 1'b0);
        chk({tag, "_en"}, lcd_en, 1'b0);
        chk({tag, "_on"}, lcd_on, 1'b1);
        chk({tag, "_blon"}, lcd_blon, 1'b1);
        chk({tag, "_ready"}, hs.in_ready, 1'b0);
        chk({tag, "_busy"}, hs.busy, 1'b1);
    endtask

    task automatic power_up(input string tag);
        bit en_low;
        int rc;
        rst = 1'b0;
        clear_mon();
        en_low = 1;
        repeat (T_PWR) begin
            tick();
            if (lcd_en !== 1'b0) en_low = 0;
        end
        chk({tag, "_pwr_en_low"}, en_low, 1);
        wait_ready(tag, rc);
        m_held = '0;
        m_prev = '0;
        model_init();
        model_redraw();
        check_burst(tag);
        if (rise_q.size() > 0) chk({tag, "_ready_time"}, rc, rise_q[$] + T_EN + T_CMD);
        chk({tag, "_idle_ready"}, hs.in_ready, 1'b1);
        chk({tag, "_idle_busy"}, hs.busy, 1'b0);
    endtask

    task automatic redraw(input string tag, input logic [DW-1:0] v, input bit change_mid);
        int acc;
        int rc;
        clear_mon();
        send(v, acc);
        if (change_mid) begin
            repeat (30) tick();
            hs.in_data = DW'(8'h3C);
        end
        wait_ready(tag, rc);
        model_redraw();
        check_burst(tag);
        if (rise_q.size() > 0) begin
            chk({tag, "_latency"}, rise_q[0], acc + 2 + T_SETUP);
            chk({tag, "_ready_time"}, rc, rise_q[$] + T_EN + T_CMD);
        end
        chk({tag, "_busy_low"}, hs.busy, 1'b0);
    endtask

    initial begin
        int acc;
        bit hit;
        rst         = 1'b1;
        hs.in_valid = 1'b0;
        hs.in_data  = '0;
        m_held      = '0;
        m_prev      = '0;
        repeat (3) tick();
        check_reset_outputs("reset");

        power_up("init");

        redraw("a5", DW'(8'hA5), 1'b1);
        redraw("dir", DW'(24'h12EF09), 1'b0);
        for (int r = 0; r < 4; r++) begin
            redraw($sformatf("rnd%0d", r), DW'($urandom), 1'b0);
        end

        // Reset while the 8th character strobe is high.
        clear_mon();
        send(DW'($urandom), acc);
        hit = 0;
        for (int i = 0; i < LIMIT; i++) begin
            if (wr_q.size() == 9 && lcd_en) begin
                hit = 1;
                break;
            end
            tick();
        end
        chk("midreset_reach", hit, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("midreset");
        tick();
        power_up("reinit");
        redraw("post", DW'($urandom), 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
